// File: rtl/gpio_ctrl_pkg.sv
// ============================================================================
// Module   : gpio_ctrl_pkg
// Brief    : Shared types, offsets and helpers for the GPIO controller CSRs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_ctrl_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_t;

    localparam logic [9:0] GPIO_INTR_STATUS_OFFSET = 10'h200;

    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] mask;
        mask = '0;
        for (int n = 0; n < 4; n++) begin
            mask[n*8 +: 8] = {8{strb[n]}};
        end
        return mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_ctrl_apb_resp_fsm.sv
// ============================================================================
// Module   : gpio_ctrl_apb_resp_fsm
// Brief    : APB responder sequencer with wait states and protocol checking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_ctrl_apb_resp_fsm
    import gpio_ctrl_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic psel,
    input  logic penable,
    input  logic pwrite,
    input  logic xfer_err,
    output logic pready,
    output logic pslverr,
    output logic wr_stb,
    output logic rd_stb
);

    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_wait_states_check
        $error("WAIT_STATES must be in 0..15");
    end

    apb_state_t r_state;
    apb_state_t w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_done;
    logic       w_proto_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done      = 1'b0;
        w_proto_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (psel && !penable) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = 4'(WAIT_STATES);
                end else if (psel && penable) begin
                    w_proto_err = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end else if (penable) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    // A repeated setup phase restarts the wait sequence.
                    w_cnt_nxt = 4'(WAIT_STATES);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are held low during reset so an in-flight transfer never completes.
    assign pready  = !rst && (w_done || w_proto_err);
    assign pslverr = !rst && (w_proto_err || (w_done && xfer_err));
    assign wr_stb  = !rst && w_done && pwrite;
    assign rd_stb  = !rst && w_done && !pwrite;

endmodule

`default_nettype wire

// File: rtl/gpio_ctrl_intr_status_csr.sv
// ============================================================================
// Module   : gpio_ctrl_intr_status_csr
// Brief    : Sticky W1C GPIO interrupt status register behind an APB responder.
//            Define GPIO_INTR_IRQ_REG_EN to register the irq output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_ctrl_intr_status_csr
    import gpio_ctrl_pkg::*;
#(
    parameter int NUM_BANKS     = 4,
    parameter int PINS_PER_BANK = 8,
    parameter int WAIT_STATES   = 0,
    parameter int STATUS_W      = NUM_BANKS * PINS_PER_BANK
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pwrite,
    input  logic                psel,
    input  logic                penable,
    input  logic [3:0]          pstrb,
    input  logic [31:0]         pwdata,
    output logic [31:0]         prdata,
    output logic                pready,
    output logic                pslverr,
    input  logic [STATUS_W-1:0] intr_event,
    output logic                irq
);

    if (STATUS_W > 32 || STATUS_W < 1) begin : g_status_w_check
        $error("STATUS_W = NUM_BANKS*PINS_PER_BANK must be in 1..32");
    end

    logic [STATUS_W-1:0] r_status;
    logic [STATUS_W-1:0] w_clr;
    logic [31:0]         w_req;
    logic                w_req_err;
    logic                w_xfer_err;
    logic                w_wr_stb;
    logic                w_rd_stb;

    assign w_req = pwdata & strb_to_mask(pstrb);

    // Clear requests that reach past the implemented bits are rejected whole.
    if (STATUS_W < 32) begin : g_req_hi
        assign w_req_err = |w_req[31:STATUS_W];
    end else begin : g_req_full
        assign w_req_err = 1'b0;
    end

    assign w_xfer_err = pwrite && w_req_err;

    gpio_ctrl_apb_resp_fsm #(
        .WAIT_STATES (WAIT_STATES)
    ) u_fsm (
        .clk      (clk),
        .rst      (rst),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .xfer_err (w_xfer_err),
        .pready   (pready),
        .pslverr  (pslverr),
        .wr_stb   (w_wr_stb),
        .rd_stb   (w_rd_stb)
    );

    assign w_clr = (w_wr_stb && !w_req_err) ? w_req[STATUS_W-1:0] : '0;

    // Set is applied after clear so a simultaneous event wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_status <= '0;
        end else begin
            r_status <= (r_status & ~w_clr) | intr_event;
        end
    end

    assign prdata = w_rd_stb ? 32'(r_status) : 32'd0;

`ifdef GPIO_INTR_IRQ_REG_EN
    logic r_irq;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |r_status;
        end
    end
    assign irq = r_irq;
`else
    assign irq = |r_status;
`endif

endmodule

`default_nettype wire
